// File: rtl/bus_pkg.sv
// Shared definitions for the serial bus master port:
// FSM state encoding, default widths and address field positions.
package bus_pkg;

  localparam int ADDR_W_DEF = 14;
  localparam int DATA_W_DEF = 8;

  // Address layout: [SID_MSB:SID_LSB] slave id, below that the location.
  localparam int SID_MSB = 13;
  localparam int SID_LSB = 12;
  localparam int LOC_W   = 12;

  typedef enum logic [3:0] {
    S_IDLE,
    S_REQ,
    S_ADDR,
    S_WAIT_ACK,
    S_WAIT_RDY,
    S_WDATA,
    S_RDATA,
    S_DONE,
    S_SPLIT
  } state_t;

endpackage

// File: rtl/bus_shift_reg.sv
// Parallel-load / serial-out and serial-in / parallel-out
// shift register, LSB leaves first, serial input enters at MSB.
module bus_shift_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         shift,
  input  logic [W-1:0] pdata,
  input  logic         sin,
  output logic         sout,
  output logic [W-1:0] q
);

  // Load wins over shift; shifting moves toward bit 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= '0;
    end else if (load) begin
      q <= pdata;
    end else if (shift) begin
      q <= {sin, q[W-1:1]};
    end
  end

  assign sout = q[0];

endmodule

// File: rtl/bus_master_port.sv
// Per-master serial bus port: latches one transaction, arbitrates,
// serialises address/write data, deserialises read data, bursts, split.
module bus_master_port
  import bus_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int ACK_TIMEOUT = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              read_en,
  input  logic [2:0]        burst_mode,
  input  logic [DATA_W-1:0] data_in,
  input  logic [ADDR_W-1:0] addr_in,
  output logic              bus_request,
  input  logic              bus_grant,
  input  logic              bus_split,
  output logic              bus_valid,
  output logic              bus_rw,
  output logic              bus_addr_out,
  output logic              bus_data_out,
  input  logic              bus_data_in,
  input  logic              slave_ack,
  input  logic              slave_ready,
  output logic              wdata_req,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              busy,
  output logic              error
);

  localparam logic [3:0] ADDR_LAST = 4'(ADDR_W - 1);
  localparam logic [3:0] DATA_LAST = 4'(DATA_W - 1);
  localparam logic [3:0] TO_LAST   = 4'(ACK_TIMEOUT - 1);

  state_t state, nstate;

  logic [3:0] bit_cnt;
  logic [2:0] beat_cnt;
  logic [2:0] burst_q;
  logic       rd_flag;

  logic cnt_clr, cnt_inc;
  logic beat_clr, beat_inc;
  logic ld_addr, sh_addr;
  logic ld_wr, sh_wr, sh_rd;
  logic to_err, rd_last;

  logic              addr_sout, wr_sout, rd_sout;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wr_q, rd_q;
  logic              unused;

  bus_shift_reg #(.W(ADDR_W)) u_addr (
    .clk   (clk),
    .reset (reset),
    .load  (ld_addr),
    .shift (sh_addr),
    .pdata (addr_in),
    .sin   (1'b0),
    .sout  (addr_sout),
    .q     (addr_q)
  );

  bus_shift_reg #(.W(DATA_W)) u_wdata (
    .clk   (clk),
    .reset (reset),
    .load  (ld_wr),
    .shift (sh_wr),
    .pdata (data_in),
    .sin   (1'b0),
    .sout  (wr_sout),
    .q     (wr_q)
  );

  bus_shift_reg #(.W(DATA_W)) u_rdata (
    .clk   (clk),
    .reset (reset),
    .load  (1'b0),
    .shift (sh_rd),
    .pdata ('0),
    .sin   (bus_data_in),
    .sout  (rd_sout),
    .q     (rd_q)
  );

  // Parallel views of the outgoing registers are not needed here.
  assign unused = ^{addr_q, wr_q, rd_sout, rd_q[0]};

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= nstate;
    end
  end

  // Next state, bus outputs and datapath controls.
  always_comb begin
    nstate      = state;
    bus_request = 1'b0;
    bus_valid   = 1'b0;
    busy        = 1'b0;
    wdata_req   = 1'b0;
    cnt_clr     = 1'b0;
    cnt_inc     = 1'b0;
    beat_clr    = 1'b0;
    beat_inc    = 1'b0;
    ld_addr     = 1'b0;
    sh_addr     = 1'b0;
    ld_wr       = 1'b0;
    sh_wr       = 1'b0;
    sh_rd       = 1'b0;
    to_err      = 1'b0;
    rd_last     = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (enable) begin
          nstate   = S_REQ;
          ld_addr  = 1'b1;
          cnt_clr  = 1'b1;
          beat_clr = 1'b1;
        end
      end
      S_REQ: begin
        busy        = 1'b1;
        bus_request = 1'b1;
        if (bus_grant) begin
          nstate  = S_ADDR;
          cnt_clr = 1'b1;
        end
      end
      S_ADDR: begin
        busy        = 1'b1;
        bus_request = 1'b1;
        bus_valid   = 1'b1;
        sh_addr     = 1'b1;
        if (bit_cnt == ADDR_LAST) begin
          nstate  = S_WAIT_ACK;
          cnt_clr = 1'b1;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      S_WAIT_ACK: begin
        busy        = 1'b1;
        bus_request = 1'b1;
        if (slave_ack) begin
          nstate  = S_WAIT_RDY;
          cnt_clr = 1'b1;
        end else if (bit_cnt == TO_LAST) begin
          nstate  = S_IDLE;
          to_err  = 1'b1;
          cnt_clr = 1'b1;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      S_WAIT_RDY: begin
        busy        = 1'b1;
        bus_request = 1'b1;
        if (bus_split) begin
          nstate = S_SPLIT;
        end else if (slave_ready) begin
          cnt_clr = 1'b1;
          if (rd_flag) begin
            nstate = S_RDATA;
          end else begin
            nstate    = S_WDATA;
            wdata_req = 1'b1;
            ld_wr     = 1'b1;
          end
        end
      end
      S_WDATA: begin
        busy        = 1'b1;
        bus_request = 1'b1;
        bus_valid   = 1'b1;
        sh_wr       = 1'b1;
        if (bit_cnt == DATA_LAST) begin
          cnt_clr = 1'b1;
          if (beat_cnt == burst_q) begin
            nstate = S_DONE;
          end else begin
            nstate   = S_WAIT_RDY;
            beat_inc = 1'b1;
          end
        end else begin
          cnt_inc = 1'b1;
        end
      end
      S_RDATA: begin
        busy        = 1'b1;
        bus_request = 1'b1;
        sh_rd       = 1'b1;
        if (bit_cnt == DATA_LAST) begin
          cnt_clr = 1'b1;
          rd_last = 1'b1;
          if (beat_cnt == burst_q) begin
            nstate = S_DONE;
          end else begin
            nstate   = S_WAIT_RDY;
            beat_inc = 1'b1;
          end
        end else begin
          cnt_inc = 1'b1;
        end
      end
      S_DONE: begin
        nstate = S_IDLE;
      end
      S_SPLIT: begin
        busy        = 1'b1;
        bus_request = 1'b1;
        if (bus_grant) begin
          nstate = S_WAIT_RDY;
        end
      end
      default: begin
        nstate = S_IDLE;
      end
    endcase
  end

  assign bus_rw       = bus_valid & rd_flag;
  assign bus_addr_out = sh_addr & addr_sout;
  assign bus_data_out = sh_wr & wr_sout;

  // Bit and beat counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bit_cnt  <= '0;
      beat_cnt <= '0;
    end else begin
      if (cnt_clr) begin
        bit_cnt <= '0;
      end else if (cnt_inc) begin
        bit_cnt <= bit_cnt + 4'd1;
      end
      if (beat_clr) begin
        beat_cnt <= '0;
      end else if (beat_inc) begin
        beat_cnt <= beat_cnt + 3'd1;
      end
    end
  end

  // Transaction attributes captured on accept.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_flag <= 1'b0;
      burst_q <= '0;
    end else if (ld_addr) begin
      rd_flag <= read_en;
      burst_q <= burst_mode;
    end
  end

  // Read byte capture and one-cycle status pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_out   <= '0;
      data_valid <= 1'b0;
      error      <= 1'b0;
    end else begin
      data_valid <= rd_last;
      error      <= to_err;
      if (rd_last) begin
        data_out <= {bus_data_in, rd_q[DATA_W-1:1]};
      end
    end
  end

endmodule

// File: tb/tb_bus_master_port.sv
// Bench for bus_master_port: reactive arbiter/slave model,
// directed cases then randomized transactions.
module tb_bus_master_port;
  import bus_pkg::*;

  localparam int AW = 14;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          enable;
  logic          read_en;
  logic [2:0]    burst_mode;
  logic [DW-1:0] data_in;
  logic [AW-1:0] addr_in;
  logic          bus_request;
  logic          bus_grant;
  logic          bus_split;
  logic          bus_valid;
  logic          bus_rw;
  logic          bus_addr_out;
  logic          bus_data_out;
  logic          bus_data_in;
  logic          slave_ack;
  logic          slave_ready;
  logic          wdata_req;
  logic [DW-1:0] data_out;
  logic          data_valid;
  logic          busy;
  logic          error;

  bus_master_port dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .read_en      (read_en),
    .burst_mode   (burst_mode),
    .data_in      (data_in),
    .addr_in      (addr_in),
    .bus_request  (bus_request),
    .bus_grant    (bus_grant),
    .bus_split    (bus_split),
    .bus_valid    (bus_valid),
    .bus_rw       (bus_rw),
    .bus_addr_out (bus_addr_out),
    .bus_data_out (bus_data_out),
    .bus_data_in  (bus_data_in),
    .slave_ack    (slave_ack),
    .slave_ready  (slave_ready),
    .wdata_req    (wdata_req),
    .data_out     (data_out),
    .data_valid   (data_valid),
    .busy         (busy),
    .error        (error)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", tag, got, exp);
    end
  endtask

  // Transaction description used by the slave/arbiter model.
  logic          t_rd;
  logic [2:0]    t_burst;
  logic [AW-1:0] t_addr;
  logic [7:0]    t_wr [8];
  logic [7:0]    t_rdb [8];
  int            t_gdly;
  int            t_adly;
  int            t_rdly;
  int            t_split;

  function automatic logic [31:0] outs_packed();
    return {bus_request, bus_valid, bus_rw, bus_addr_out,
            bus_data_out, wdata_req, data_out, data_valid,
            busy, error};
  endfunction

  task automatic run_txn(input string name);
    int ss, cnt, beat, rbit, nvalid, gcnt, ndv, nwreq;
    int rwbad, nerr, cyc, last_cyc, err_cyc, beats;
    bit in_split, split_done, seen_busy, fin;
    logic [AW-1:0] acap;
    logic [7:0] wcap [8];
    ss = 0; cnt = 0; beat = 0; rbit = 0; nvalid = 0;
    gcnt = 0; ndv = 0; nwreq = 0; rwbad = 0; nerr = 0;
    cyc = 0; last_cyc = 0; err_cyc = 0;
    in_split = 0; split_done = 0; seen_busy = 0; fin = 0;
    acap = '0;
    for (int i = 0; i < 8; i++) wcap[i] = '0;
    beats = int'(t_burst) + 1;
    @(negedge clk);
    enable     = 1'b1;
    read_en    = t_rd;
    burst_mode = t_burst;
    addr_in    = t_addr;
    while (!fin && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (busy) begin
        seen_busy = 1;
        enable = 1'b0;
      end
      if (bus_valid) begin
        if (bus_rw !== t_rd) rwbad++;
        if (nvalid < AW) acap[nvalid] = bus_addr_out;
        else if (nvalid < AW + 64)
          wcap[(nvalid-AW)/8][(nvalid-AW)%8] = bus_data_out;
        nvalid++;
        if (nvalid == AW) last_cyc = cyc;
      end
      if (data_valid) begin
        if (ndv < 8)
          check($sformatf("%s rbyte%0d", name, ndv),
                32'(data_out), 32'(t_rdb[ndv]));
        ndv++;
      end
      if (error) begin
        nerr++;
        err_cyc = cyc;
        check({name, " err_req"}, 32'(bus_request), 0);
      end
      if (seen_busy && !busy) begin
        fin = 1;
        check({name, " end_req"}, 32'(bus_request), 0);
      end
      slave_ack   = 1'b0;
      slave_ready = 1'b0;
      bus_split   = 1'b0;
      if (!bus_request) begin
        bus_grant = 1'b0;
        gcnt = 0;
      end else if (!bus_grant && !in_split) begin
        if (gcnt >= t_gdly) bus_grant = 1'b1;
        else gcnt++;
      end
      case (ss)
        0: if (nvalid >= AW) begin
             if (t_adly < 0) ss = 7;
             else begin ss = 1; cnt = t_adly; end
           end
        1: if (cnt > 0) cnt--;
           else begin
             slave_ack = 1'b1;
             ss = 2;
             cnt = t_rdly;
           end
        2: if (cnt > 0) cnt--;
           else if (beat == t_split && !split_done) begin
             bus_split = 1'b1;
             bus_grant = 1'b0;
             in_split = 1;
             split_done = 1;
             ss = 5;
             cnt = 9;
           end else begin
             slave_ready = 1'b1;
             data_in = t_wr[beat];
             rbit = 0;
             ss = t_rd ? 3 : 4;
           end
        3: begin
             bus_data_in = t_rdb[beat][rbit];
             rbit++;
             if (rbit == 8) begin
               beat++;
               ss = (beat >= beats) ? 6 : 2;
               cnt = t_rdly;
             end
           end
        4: if (nvalid >= AW + 8*(beat+1)) begin
             beat++;
             ss = (beat >= beats) ? 6 : 2;
             cnt = t_rdly;
           end
        5: if (cnt > 1) cnt--;
           else begin
             bus_grant = 1'b1;
             in_split = 0;
             ss = 2;
             cnt = t_rdly;
           end
        default: ;
      endcase
      #1;
      if (wdata_req) nwreq++;
    end
    check({name, " done"}, 32'(fin), 1);
    check({name, " addr"}, 32'(acap), 32'(t_addr));
    check({name, " rw"}, 32'(rwbad), 0);
    if (t_adly < 0) begin
      check({name, " nerr"}, 32'(nerr), 1);
      check({name, " err_at"}, 32'(err_cyc - last_cyc), 9);
      check({name, " vcyc"}, 32'(nvalid), AW);
      check({name, " ndv"}, 32'(ndv), 0);
    end else begin
      check({name, " nerr"}, 32'(nerr), 0);
      if (t_rd) begin
        check({name, " vcyc"}, 32'(nvalid), AW);
        check({name, " ndv"}, 32'(ndv), 32'(beats));
        check({name, " nwreq"}, 32'(nwreq), 0);
      end else begin
        check({name, " vcyc"}, 32'(nvalid), 32'(AW + 8*beats));
        check({name, " nwreq"}, 32'(nwreq), 32'(beats));
        for (int b = 0; b < beats; b++)
          check($sformatf("%s wbyte%0d", name, b),
                32'(wcap[b]), 32'(t_wr[b]));
      end
    end
    bus_grant = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic set_txn(input logic rd, input logic [2:0] bm,
                         input logic [AW-1:0] a, input int g,
                         input int ad, input int rdl, input int sp);
    t_rd = rd; t_burst = bm; t_addr = a;
    t_gdly = g; t_adly = ad; t_rdly = rdl; t_split = sp;
    for (int i = 0; i < 8; i++) begin
      t_wr[i]  = 8'($urandom);
      t_rdb[i] = 8'($urandom);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; enable = 1'b0; read_en = 1'b0;
    burst_mode = '0; data_in = '0; addr_in = '0;
    bus_grant = 1'b0; bus_split = 1'b0; bus_data_in = 1'b0;
    slave_ack = 1'b0; slave_ready = 1'b0;
    #1;
    check("reset_outs", outs_packed(), 0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("idle_outs", outs_packed(), 0);

    set_txn(1'b0, 3'd0, 14'd5012, 2, 1, 1, -1);
    t_wr[0] = 8'd78;
    run_txn("t1_write");

    set_txn(1'b1, 3'd0, 14'd1001, 1, 0, 1, -1);
    t_rdb[0] = 8'd62;
    run_txn("t2_read");

    set_txn(1'b1, 3'd3, 14'($urandom), 0, 2, 1, -1);
    run_txn("t3_burst");

    set_txn(1'b1, 3'd0, 14'($urandom), 1, 1, 2, 0);
    run_txn("t4_split");

    set_txn(1'b0, 3'd0, 14'($urandom), 1, -1, 1, -1);
    run_txn("t5_noack");

    set_txn(1'b0, 3'd7, 14'($urandom), 0, 7, 1, 5);
    run_txn("ack_edge_burst7");

    for (int n = 0; n < 25; n++) begin
      int bm;
      bm = int'($urandom_range(7, 0));
      set_txn(1'($urandom), 3'(bm), 14'($urandom),
              int'($urandom_range(4, 0)),
              ($urandom_range(9, 0) == 0) ? -1
                : int'($urandom_range(7, 0)),
              int'($urandom_range(3, 1)),
              ($urandom_range(2, 0) == 0)
                ? int'($urandom_range(bm, 0)) : -1);
      run_txn($sformatf("rnd%0d", n));
    end

    // Asynchronous reset in the middle of the address phase.
    @(negedge clk);
    enable = 1'b1;
    read_en = 1'b0;
    addr_in = 14'($urandom);
    bus_grant = 1'b1;
    begin
      int w;
      w = 0;
      while (!bus_valid && w < 50) begin
        @(negedge clk);
        w++;
      end
      check("rst_reach_addr", 32'(bus_valid), 1);
    end
    enable = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    #1;
    check("rst_mid_addr", outs_packed(), 0);
    bus_grant = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check("post_rst_idle", outs_packed(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
